// File: rtl/weight_stream_ctrl.sv
// Weight ROM read sequencer: issues a contiguous read run and presents the words as a
// valid/ready stream through a 2-entry skid FIFO. Define WEIGHT_STREAM_LAST_EN to add m_last.
module weight_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned ADDR_DEPTH = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(ADDR_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ce,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
`ifdef WEIGHT_STREAM_LAST_EN
  output logic                  m_last,
`endif
  input  logic                  m_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0] fdata_q [2];
  logic [DATA_WIDTH-1:0] fdata_d [2];
  logic                  pop, push, issue;
  logic [2:0]            occ;

  // Occupancy after this edge, counting the read already in flight.
  always_comb begin
    pop   = (fcnt_q != 2'd0) && m_ready;
    push  = inflight_q;
    occ   = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == StRun) && (rem_q != '0) && (occ < 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    hold_addr_d = hold_addr_q;
    inflight_d  = issue;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            addr_d  = base_addr;
            rem_d   = count;
            state_d = StRun;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rem_d       = rem_q - CNT_WIDTH'(1);
          hold_addr_d = addr_q;
        end
        if (pop && (rem_q == '0) && !inflight_q && (fcnt_q == 2'd1)) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shift-register FIFO: entry 0 is always the head.
  always_comb begin
    fdata_d = fdata_q;
    fcnt_d  = fcnt_q;
    case ({push, pop})
      2'b10: begin
        fdata_d[fcnt_q[0]] = mem_dout;
        fcnt_d             = fcnt_q + 2'd1;
      end
      2'b01: begin
        fdata_d[0] = fdata_q[1];
        fcnt_d     = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          fdata_d[0] = mem_dout;
        end else begin
          fdata_d[0] = fdata_q[1];
          fdata_d[1] = mem_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      hold_addr_q <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      fcnt_q      <= 2'd0;
      fdata_q[0]  <= '0;
      fdata_q[1]  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_addr_q <= hold_addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      fcnt_q      <= fcnt_d;
      fdata_q     <= fdata_d;
    end
  end

`ifdef WEIGHT_STREAM_LAST_EN
  logic       inflight_last_q, inflight_last_d;
  logic [1:0] flast_q, flast_d;

  always_comb begin
    inflight_last_d = issue && (rem_q == CNT_WIDTH'(1));
    flast_d         = flast_q;
    case ({push, pop})
      2'b10: flast_d[fcnt_q[0]] = inflight_last_q;
      2'b01: flast_d[0] = flast_q[1];
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          flast_d[0] = inflight_last_q;
        end else begin
          flast_d[0] = flast_q[1];
          flast_d[1] = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_last_q <= 1'b0;
      flast_q         <= 2'b00;
    end else begin
      inflight_last_q <= inflight_last_d;
      flast_q         <= flast_d;
    end
  end

  assign m_last = m_valid & flast_q[0];
`endif

  assign mem_ce   = issue;
  assign mem_addr = issue ? addr_q : hold_addr_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign m_valid  = (fcnt_q != 2'd0);
  assign m_data   = fdata_q[0];

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Randomized self-checking bench for weight_stream_ctrl against a transaction-level model.
module tb_weight_stream_ctrl;

  localparam int unsigned DW = 1024;
  localparam int unsigned AD = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, mem_ce, m_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
`ifdef WEIGHT_STREAM_LAST_EN
  logic          m_last;
`endif

  always #5 clk = ~clk;

  weight_stream_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_DEPTH(AD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .mem_ce   (mem_ce),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
`ifdef WEIGHT_STREAM_LAST_EN
    .m_last   (m_last),
`endif
    .m_ready  (m_ready)
  );

  // Weight ROM with one cycle of read latency.
  logic [DW-1:0] rom [AD];
  always @(posedge clk) if (mem_ce) mem_dout <= rom[mem_addr];

  int errors = 0;
  int checks = 0;
  int dut_hs = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (low 96 bits) t=%0t", tag, got[95:0], exp[95:0],
               $time);
    end
  endtask

  // Model: command progress in words, plus words issued vs. words sitting in the buffer.
  bit            md_busy, md_fin, md_run, iss_prev;
  int            rem_issue, nxt_addr, last_addr, words_left, inbuf;
  logic [DW-1:0] exp_q [$];

  task automatic model_reset();
    md_busy = 0; md_fin = 0; md_run = 0; iss_prev = 0;
    rem_issue = 0; nxt_addr = 0; last_addr = 0; words_left = 0; inbuf = 0;
    exp_q.delete();
  endtask

  function automatic bit rdy(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic step(input bit st, input int base, input int cnt, input bit rd);
    bit pop_e, ce_e, fin_n, busy_n;
    int occ;
    @(negedge clk);
    start = st; base_addr = AW'(base); count = CW'(cnt); m_ready = rd;
    #1;
    check_eq("busy", DW'(busy), DW'(md_busy));
    check_eq("done", DW'(done), DW'(md_fin));
    check_eq("m_valid", DW'(m_valid), DW'(inbuf > 0));
    pop_e = (inbuf > 0) && rd;
    occ   = inbuf + int'(iss_prev) - int'(pop_e);
    ce_e  = md_run && (rem_issue > 0) && (occ < 2);
    check_eq("mem_ce", DW'(mem_ce), DW'(ce_e));
    check_eq("mem_addr", DW'(mem_addr), DW'(ce_e ? nxt_addr : last_addr));
    if (inbuf > 0) begin
      check_eq("m_data", m_data, exp_q[0]);
`ifdef WEIGHT_STREAM_LAST_EN
      check_eq("m_last", DW'(m_last), DW'(words_left == 1));
`endif
    end
    if (m_valid && m_ready) dut_hs++;
    fin_n = 0; busy_n = md_busy;
    if (ce_e) begin
      exp_q.push_back(rom[nxt_addr]);
      last_addr = nxt_addr;
      nxt_addr  = (nxt_addr + 1) % AD;
      rem_issue--;
    end
    if (pop_e) begin
      void'(exp_q.pop_front());
      inbuf--;
      words_left--;
      if (words_left == 0) begin md_run = 0; fin_n = 1; end
    end
    inbuf += int'(iss_prev);
    iss_prev = ce_e;
    if (md_fin) busy_n = 0;
    if (st && !md_busy) begin
      busy_n = 1;
      if (cnt == 0) fin_n = 1;
      else begin
        md_run = 1; rem_issue = cnt; words_left = cnt; nxt_addr = base;
      end
    end
    md_fin = fin_n; md_busy = busy_n;
  endtask

  // junk: 0 none, 1 occasional, 2 every cycle -- starts issued while busy must be ignored.
  task automatic run_cmd(input int base, input int cnt, input int pct, input int junk);
    int n;
    bit js;
    dut_hs = 0;
    step(1'b1, base, cnt, rdy(pct));
    n = 0;
    while (md_busy && n < cnt * 40 + 50) begin
      js = (junk == 2) || (junk == 1 && $urandom_range(7) == 0);
      step(js, $urandom_range(AD - 1), $urandom_range(1, 20), rdy(pct));
      n++;
    end
    check_eq("handshakes", DW'(dut_hs), DW'(cnt));
    step(1'b0, 0, 0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    #1;
    check_eq("rst_busy", DW'(busy), '0);
    check_eq("rst_done", DW'(done), '0);
    check_eq("rst_m_valid", DW'(m_valid), '0);
    check_eq("rst_mem_ce", DW'(mem_ce), '0);
    check_eq("rst_mem_addr", DW'(mem_addr), '0);
    check_eq("rst_m_data", m_data, '0);
`ifdef WEIGHT_STREAM_LAST_EN
    check_eq("rst_m_last", DW'(m_last), '0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(AD); i++) begin
      for (int w = 1; w < int'(DW / 32); w++) rom[i][w*32 +: 32] = $urandom;
      rom[i][31:0] = i;
    end
    model_reset();
    do_reset();
    repeat (5) step(1'b0, 0, 0, 1'b1);
    run_cmd(10, 4, 100, 2);
    run_cmd(AD - 2, 4, 100, 0);
    run_cmd(0, 8, 50, 1);
    run_cmd(5, 0, 100, 0);
    // Reset while a read is in flight.
    step(1'b1, 100, 16, 1'b1);
    repeat (4) step(1'b0, 0, 0, 1'b1);
    check_eq("inflight_before_rst", DW'(mem_ce), DW'(1));
    do_reset();
    step(1'b0, 0, 0, 1'b1);
    run_cmd(200, 2, 100, 0);
    for (int k = 0; k < 12; k++) begin
      run_cmd($urandom_range(AD - 1), $urandom_range(1, 24), $urandom_range(20, 100), 1);
    end
    run_cmd(37, AD, 70, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
